// File: rtl/meas_pkg.sv
// -----------------------------------------------------------------------------
// meas_pkg
// Shared constants and types for the measurement channels and the result
// write arbiter. The measure blocks and the arbiter import this package so
// that channel count and word width stay consistent everywhere.
// -----------------------------------------------------------------------------
package meas_pkg;
    localparam int NUM_CH = 5;
    localparam int DATA_W = 64;
    localparam int CH_W   = $clog2(NUM_CH);

    typedef logic [DATA_W-1:0] meas_word_t;
    typedef logic [CH_W-1:0]   ch_idx_t;

    // Channel index plus one, wrapping NUM_CH-1 back to 0.
    function automatic ch_idx_t ch_inc(input ch_idx_t c);
        return (c == ch_idx_t'(NUM_CH - 1)) ? '0 : ch_idx_t'(c + 1'b1);
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: scans req_i starting at ptr_i,
// wrapping modulo NUM_CH, and grants the first requester found.
// Ports:
//   req_i      in   NUM_CH  request vector
//   ptr_i      in   CH_W    first index to examine
//   gnt_o      out  NUM_CH  one-hot grant (all zero when nothing requests)
//   gnt_idx_o  out  CH_W    index of the granted requester
//   any_o      out  1       at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter
    import meas_pkg::*;
(
    input  logic [NUM_CH-1:0] req_i,
    input  ch_idx_t           ptr_i,
    output logic [NUM_CH-1:0] gnt_o,
    output ch_idx_t           gnt_idx_o,
    output logic              any_o
);
    logic [CH_W:0] w_sum;
    ch_idx_t       w_idx;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        w_sum     = '0;
        w_idx     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            // One extra bit so ptr+i cannot overflow before the modulo fold.
            w_sum = {1'b0, ptr_i} + (CH_W+1)'(i);
            if (w_sum >= (CH_W+1)'(NUM_CH))
                w_sum = w_sum - (CH_W+1)'(NUM_CH);
            w_idx = w_sum[CH_W-1:0];
            if (!any_o && req_i[w_idx]) begin
                any_o        = 1'b1;
                gnt_o[w_idx] = 1'b1;
                gnt_idx_o    = w_idx;
            end
        end
    end
endmodule

// File: rtl/meas_wr_arbiter.sv
// -----------------------------------------------------------------------------
// meas_wr_arbiter
// Collects per-channel measurement results into one-entry holding buffers and
// serialises them onto the single regfile write port with round-robin order.
// Ports:
//   clk_i          in   1              clock
//   rst_i          in   1              async, active-high reset
//   raw_wr_en_i    in   NUM_CH         per-channel result-valid pulse
//   raw_wr_data_i  in   NUM_CH x DATA_W per-channel result word
//   arb_en_i       in   1              allow new grants
//   reg_wr_rdy_i   in   1              sink accepts presented write
//   ovr_clr_i      in   1              clears sticky overrun flags
//   reg_wr_en_o    out  1              write valid
//   reg_wr_data_o  out  DATA_W         write data
//   reg_wr_ch_o    out  CH_W           source channel of the write
//   ovr_o          out  NUM_CH         sticky overrun flags
//   busy_o         out  1              any pending entry or write presented
// -----------------------------------------------------------------------------
module meas_wr_arbiter
    import meas_pkg::*;
(
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_CH-1:0]            raw_wr_en_i,
    input  meas_word_t [NUM_CH-1:0]      raw_wr_data_i,
    input  logic                         arb_en_i,
    input  logic                         reg_wr_rdy_i,
    input  logic                         ovr_clr_i,
    output logic                         reg_wr_en_o,
    output meas_word_t                   reg_wr_data_o,
    output ch_idx_t                      reg_wr_ch_o,
    output logic [NUM_CH-1:0]            ovr_o,
    output logic                         busy_o
);
    logic [NUM_CH-1:0]       r_pend;
    meas_word_t [NUM_CH-1:0] r_buf;
    logic [NUM_CH-1:0]       r_ovr;
    ch_idx_t                 r_rr;
    logic                    r_wr_en;
    meas_word_t              r_wr_data;
    ch_idx_t                 r_wr_ch;
    logic                    r_busy;

    logic [NUM_CH-1:0] w_gnt;
    logic [NUM_CH-1:0] w_gnt_q;
    ch_idx_t           w_gnt_idx;
    logic              w_any;
    logic              w_free;
    logic              w_grant;
    logic [NUM_CH-1:0] w_pend_nxt;
    logic [NUM_CH-1:0] w_ovr_nxt;
    logic              w_en_nxt;

    rr_arbiter u_rr (
        .req_i     (r_pend),
        .ptr_i     (r_rr),
        .gnt_o     (w_gnt),
        .gnt_idx_o (w_gnt_idx),
        .any_o     (w_any)
    );

    assign w_free  = !r_wr_en || reg_wr_rdy_i;
    assign w_grant = w_free && arb_en_i && w_any;
    assign w_gnt_q = w_gnt & {NUM_CH{w_grant}};

    // A fresh pulse always re-arms pend, even on the channel being granted:
    // the grant takes the old buffer word and the new one waits its turn.
    assign w_pend_nxt = raw_wr_en_i | (r_pend & ~w_gnt_q);
    // Overrun only when unread data is overwritten; set wins over clear.
    assign w_ovr_nxt  = (raw_wr_en_i & r_pend & ~w_gnt_q)
                      | (r_ovr & ~{NUM_CH{ovr_clr_i}});
    // A stalled write stays up; a free slot without a grant drops valid.
    assign w_en_nxt   = w_grant || (r_wr_en && !w_free);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pend    <= '0;
            r_buf     <= '0;
            r_ovr     <= '0;
            r_rr      <= '0;
            r_wr_en   <= 1'b0;
            r_wr_data <= '0;
            r_wr_ch   <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_pend  <= w_pend_nxt;
            r_ovr   <= w_ovr_nxt;
            r_wr_en <= w_en_nxt;
            r_busy  <= (|w_pend_nxt) || w_en_nxt;
            for (int k = 0; k < NUM_CH; k++) begin
                if (raw_wr_en_i[k])
                    r_buf[k] <= raw_wr_data_i[k];
            end
            if (w_grant) begin
                r_wr_data <= r_buf[w_gnt_idx];
                r_wr_ch   <= w_gnt_idx;
                r_rr      <= ch_inc(w_gnt_idx);
            end
        end
    end

    assign reg_wr_en_o   = r_wr_en;
    assign reg_wr_data_o = r_wr_data;
    assign reg_wr_ch_o   = r_wr_ch;
    assign ovr_o         = r_ovr;
    assign busy_o        = r_busy;
endmodule
